// File: rtl/program_state_tracker.sv
// Registered program-state holder: privilege, C-extension enable and satp, with WARL
// filtering, a change epoch and a flush handshake on translation-relevant changes.
module program_state_tracker #(
  parameter int         XLEN        = 32,
  parameter int         EPOCH_W     = 4,
  parameter logic [1:0] RESET_PRIV  = 2'b11,
  parameter logic       RESET_ISA_C = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_upd_valid,
  output logic                o_upd_ready,
  input  logic [2:0]          i_upd_mask,
  input  logic [1:0]          i_upd_priv,
  input  logic                i_upd_isa_c,
  input  logic [XLEN-1:0]     i_upd_satp,
  output logic [XLEN+2:0]     o_ps,
  output logic [EPOCH_W-1:0]  o_epoch,
  output logic                o_flush_req,
  input  logic                i_flush_ack,
  output logic                o_upd_err
);

  // Handshake: an update transfers on a rising edge where i_upd_valid && o_upd_ready.
  // o_upd_ready is decoded from state only, so the requester must hold its update
  // (valid and fields stable) until that edge.

  // satp layout, MSB first: MODE, ASID, PPN. Sv32 = 1/9/22 bits, Sv39 = 4/16/44 bits.
  localparam int MODE_W = (XLEN == 64) ? 4 : 1;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("program_state_tracker: XLEN must be 32 or 64");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           priv_q, priv_d;
  logic                 isa_c_q, isa_c_d;
  logic [XLEN-1:0]      satp_q, satp_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 priv_ok;
  logic                 satp_ok;
  logic                 wr_priv, wr_isa_c, wr_satp;
  logic                 priv_chg, isa_c_chg, satp_chg;
  logic [MODE_W-1:0]    upd_mode;

  assign upd_mode = i_upd_satp[XLEN-1 -: MODE_W];

  if (XLEN == 64) begin : g_sv39
    // Only Bare (0) and Sv39 (8) are implemented translation modes.
    assign satp_ok = (upd_mode == MODE_W'(0)) || (upd_mode == MODE_W'(8));
  end else begin : g_sv32
    assign satp_ok = 1'b1;
  end

  assign priv_ok   = (i_upd_priv != 2'b10);
  assign accept    = i_upd_valid && (state_q == IDLE);
  assign wr_priv   = accept && i_upd_mask[0] && priv_ok;
  assign wr_isa_c  = accept && i_upd_mask[1];
  assign wr_satp   = accept && i_upd_mask[2] && satp_ok;
  assign priv_chg  = wr_priv  && (i_upd_priv  != priv_q);
  assign isa_c_chg = wr_isa_c && (i_upd_isa_c != isa_c_q);
  assign satp_chg  = wr_satp  && (i_upd_satp  != satp_q);

  always_comb begin
    state_d = state_q;
    priv_d  = priv_q;
    isa_c_d = isa_c_q;
    satp_d  = satp_q;
    epoch_d = epoch_q;
    err_d   = accept && ((i_upd_mask[0] && !priv_ok) || (i_upd_mask[2] && !satp_ok));

    if (wr_priv)  priv_d  = i_upd_priv;
    if (wr_isa_c) isa_c_d = i_upd_isa_c;
    if (wr_satp)  satp_d  = i_upd_satp;
    if (priv_chg || isa_c_chg || satp_chg) epoch_d = epoch_q + EPOCH_W'(1);

    case (state_q)
      IDLE:    if (priv_chg || satp_chg) state_d = FLUSH;
      FLUSH:   if (i_flush_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      priv_q  <= RESET_PRIV;
      isa_c_q <= RESET_ISA_C;
      satp_q  <= '0;
      epoch_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      priv_q  <= priv_d;
      isa_c_q <= isa_c_d;
      satp_q  <= satp_d;
      epoch_q <= epoch_d;
      err_q   <= err_d;
    end
  end

  assign o_ps        = {priv_q, isa_c_q, satp_q};
  assign o_epoch     = epoch_q;
  assign o_upd_err   = err_q;
  assign o_upd_ready = (state_q == IDLE);
  assign o_flush_req = (state_q == FLUSH);

endmodule
